// File: rtl/jc_param.sv
// Parameterized Johnson counter with load, direction, phase decode, terminal-count pulse and an illegal-state flag.
// Optional build macro JC_SELF_CORRECT_EN: a step taken from an illegal state resets to all-zeros and pulses o_tc.
module jc_param #(
  parameter int WIDTH = 3,
  localparam int PH_W = $clog2(2*WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_Q,
  output logic [PH_W-1:0]  o_phase,
  output logic             o_tc,
  output logic             o_err
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] step_fwd, step_rev, step_nxt;
  logic             legal;
  int               ones;

  assign step_fwd = {~q_q[0], q_q[WIDTH-1:1]};
  assign step_rev = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
  assign step_nxt = i_dir ? step_rev : step_fwd;

  // Legal states are thermometer codes anchored at either end of the word.
  always_comb begin
    legal = 1'b0;
    ones  = 0;
    for (int i = 0; i <= WIDTH; i++) begin
      if (q_q == ~({WIDTH{1'b1}} >> i) || q_q == ~({WIDTH{1'b1}} << i))
        legal = 1'b1;
    end
    for (int i = 0; i < WIDTH; i++)
      ones = ones + int'(q_q[i]);
  end

  always_comb begin
    o_phase = '0;
    if (legal) begin
      if (q_q[WIDTH-1])  o_phase = PH_W'(ones);
      else if (ones != 0) o_phase = PH_W'(2*WIDTH - ones);
    end
  end

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (i_load) begin
      q_d = i_load_val;
    end else if (i_en) begin
`ifdef JC_SELF_CORRECT_EN
      if (!legal) begin
        q_d  = '0;
        tc_d = 1'b1;
      end else begin
        q_d  = step_nxt;
        tc_d = (step_nxt == '0);
      end
`else
      q_d  = step_nxt;
      tc_d = legal && (step_nxt == '0);
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      q_q  <= '0;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign o_Q   = q_q;
  assign o_tc  = tc_q;
  assign o_err = ~legal;

endmodule

// File: tb/tb_jc_param.sv
// Scoreboard bench for jc_param (WIDTH=3): driver pushes model predictions, monitor pops and compares each cycle.
module tb_jc_param;
  localparam int W    = 3;
  localparam int PH_W = $clog2(2*W);
  localparam int NST  = 2*W;

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b0, i_en = 1'b0, i_dir = 1'b0, i_load = 1'b0;
  logic [W-1:0]   i_load_val = '0;
  logic [W-1:0]   o_Q;
  logic [PH_W-1:0] o_phase;
  logic           o_tc, o_err;

  jc_param #(.WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_dir(i_dir),
    .i_load(i_load), .i_load_val(i_load_val),
    .o_Q(o_Q), .o_phase(o_phase), .o_tc(o_tc), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int q; int ph; int err; int tc; } exp_t;
  exp_t exp_q[$];
  int   checks = 0, errors = 0;
  int   seq_tab[NST];
  int   m_q = 0, m_tc = 0;

  // Phase k walks ones in from the MSB for k<=W, then drains them out from the top.
  function automatic int jseq(input int k);
    if (k <= W) return ((1 << k) - 1) << (W - k);
    return (1 << (NST - k)) - 1;
  endfunction

  function automatic int find_phase(input int v);
    for (int k = 0; k < NST; k++) if (seq_tab[k] == v) return k;
    return -1;
  endfunction

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic cyc(input bit rst, input bit ld, input bit en, input bit dir, input int val);
    int p;
    exp_t e;
    @(negedge i_clk);
    i_rst = rst; i_load = ld; i_en = en; i_dir = dir; i_load_val = W'(val);
    p = find_phase(m_q);
    if (rst) begin
      m_q = 0; m_tc = 0;
    end else if (ld) begin
      m_q = val & ((1 << W) - 1); m_tc = 0;
    end else if (en) begin
      if (p >= 0) begin
        p = dir ? (p + NST - 1) % NST : (p + 1) % NST;
        m_q = seq_tab[p];
        m_tc = (p == 0);
      end else begin
`ifdef JC_SELF_CORRECT_EN
        m_q = 0; m_tc = 1;
`else
        if (dir) m_q = ((m_q << 1) & ((1 << W) - 1)) | (((m_q >> (W-1)) & 1) ^ 1);
        else     m_q = (m_q >> 1) | (((m_q & 1) ^ 1) << (W-1));
        m_tc = 0;
`endif
      end
    end else begin
      m_tc = 0;
    end
    p = find_phase(m_q);
    e.q = m_q; e.ph = (p < 0) ? 0 : p; e.err = (p < 0); e.tc = m_tc;
    exp_q.push_back(e);
  endtask

  always @(posedge i_clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("o_Q", int'(o_Q), e.q);
      chk("o_phase", int'(o_phase), e.ph);
      chk("o_err", int'(o_err), e.err);
      chk("o_tc", int'(o_tc), e.tc);
    end
  end

  initial begin
    for (int k = 0; k < NST; k++) seq_tab[k] = jseq(k);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 5);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0);   // full forward lap
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);   // to 111
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0);   // reverse to 000
    cyc(0, 0, 1, 1, 0);                               // 000 -> 001 in reverse
    cyc(0, 0, 1, 0, 0);                               // immediate turn-around
    cyc(0, 1, 1, 0, 3);                               // load wins over enable
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);                               // load of zeros: no tc
    cyc(0, 0, 0, 0, 0);                               // hold
    cyc(0, 1, 0, 0, 5);                               // illegal load
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);                               // 110
    cyc(1, 0, 1, 0, 0);                               // reset mid-count
    cyc(0, 0, 1, 0, 0);                               // resumes at 100
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      cyc(r < 3, (r >= 3 && r < 12), $urandom_range(0, 9) < 7,
          $urandom_range(0, 3) == 0, $urandom_range(0, (1 << W) - 1));
    end
    cyc(0, 0, 0, 0, 0);
    repeat (3) @(negedge i_clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete, expected finish before %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
